// File: rtl/seq_shift_add_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_shift_add_multiplier: iterative shift-add multiplier, one multiplier  |
// | bit per clock, unsigned or two's-complement per operation.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seq_shift_add_multiplier #(
   parameter int WIDTH = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int            C_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         r_state;
   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mplier;
   logic [C_CW-1:0]    r_count;
   logic               r_neg;

   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [2*WIDTH-1:0] w_sum;

   // Magnitudes are unsigned WIDTH-bit, so -2^(WIDTH-1) maps to 2^(WIDTH-1) cleanly.
   assign w_mag_a = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
   assign w_mag_b = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;

   // Multiplicand shifts left and multiplier shifts right instead of indexing by counter.
   assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state == S_BUSY);
   assign out_valid = (r_state == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
         r_count  <= '0;
         r_neg    <= 1'b0;
         product  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                  r_mplier <= w_mag_b;
                  r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_acc    <= '0;
                  r_count  <= '0;
                  r_state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_acc    <= w_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count + 1'b1;
               if (r_count == C_LAST) begin
                  // Negating a zero magnitude stays zero modulo 2^(2*WIDTH).
                  product <= r_neg ? (~w_sum + 1'b1) : w_sum;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for seq_shift_add_multiplier: WIDTH=10 corner cases plus
// WIDTH=2/4 exhaustive and WIDTH=16 random sweeps against a golden product.
module tb_seq_shift_add_multiplier;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, sm, out_valid, out_ready, busy;
   logic [9:0]  a, b;
   logic [19:0] product;

   seq_shift_add_multiplier #(.WIDTH(10)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .signed_mode(sm), .out_valid(out_valid),
      .out_ready(out_ready), .product(product), .busy(busy)
   );

   logic [15:0] sw_a, sw_b;
   logic        sw_sm, sw_ordy;
   logic [2:0]  sw_valid;
   logic [2:0]  ir, ov, bz;
   logic [3:0]  p2;
   logic [7:0]  p4;
   logic [31:0] p16;

   seq_shift_add_multiplier #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(sw_valid[0]), .in_ready(ir[0]),
      .a(sw_a[1:0]), .b(sw_b[1:0]), .signed_mode(sw_sm), .out_valid(ov[0]),
      .out_ready(sw_ordy), .product(p2), .busy(bz[0])
   );
   seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(sw_valid[1]), .in_ready(ir[1]),
      .a(sw_a[3:0]), .b(sw_b[3:0]), .signed_mode(sw_sm), .out_valid(ov[1]),
      .out_ready(sw_ordy), .product(p4), .busy(bz[1])
   );
   seq_shift_add_multiplier #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(sw_valid[2]), .in_ready(ir[2]),
      .a(sw_a), .b(sw_b), .signed_mode(sw_sm), .out_valid(ov[2]),
      .out_ready(sw_ordy), .product(p16), .busy(bz[2])
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] golden(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input bit smode);
      longint m  = (longint'(1) << w) - 1;
      longint sx = longint'(x) & m;
      longint sy = longint'(y) & m;
      if (smode && x[w-1]) sx = sx - (longint'(1) << w);
      if (smode && y[w-1]) sy = sy - (longint'(1) << w);
      return 64'((sx * sy) & ((longint'(1) << (2 * w)) - 1));
   endfunction

   function automatic logic [31:0] sw_prod(input int k);
      case (k)
         0:       return {28'd0, p2};
         1:       return {24'd0, p4};
         default: return p16;
      endcase
   endfunction

   task automatic start10(input logic [9:0] ta, input logic [9:0] tb, input logic tsm);
      int guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      a = ta; b = tb; sm = tsm; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done10(output int lat, output int nb);
      lat = 0;
      nb  = busy ? 1 : 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
         if (busy) nb++;
      end
   endtask

   task automatic release10();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic op10(input logic [9:0] ta, input logic [9:0] tb, input logic tsm,
                       input logic [19:0] exp, input string tag);
      int lat, nb;
      start10(ta, tb, tsm);
      wait_done10(lat, nb);
      check({tag, " latency"}, lat, 10);
      check({tag, " product"}, product, exp);
      release10();
      check({tag, " in_ready"}, in_ready, 1);
   endtask

   task automatic run_sw(input int k, input logic [15:0] ta, input logic [15:0] tb,
                         input bit tsm, input string tag);
      int w     = (k == 0) ? 2 : (k == 1) ? 4 : 16;
      int guard = 0;
      int lat   = 0;
      while (!ir[k] && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      sw_a = ta; sw_b = tb; sw_sm = tsm; sw_valid[k] = 1'b1;
      @(posedge clk); #1;
      sw_valid = '0;
      check({tag, " busy"}, bz[k], 1);
      while (!ov[k] && lat < 60) begin
         @(posedge clk); #1; lat++;
      end
      check({tag, " latency"}, lat, w);
      check({tag, " product"}, sw_prod(k), golden(w, ta, tb, tsm));
      sw_ordy = 1'b1;
      @(posedge clk); #1;
      sw_ordy = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, nb;
      bit stable;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sm = 1'b0;
      sw_a = '0; sw_b = '0; sw_sm = 1'b0; sw_valid = '0; sw_ordy = 1'b0;
      #12;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset busy", busy, 0);
      check("reset product", product, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Unsigned max with busy-duration check
      start10(10'd1023, 10'd1023, 1'b0);
      wait_done10(lat, nb);
      check("umax latency", lat, 10);
      check("umax busy cycles", nb, 10);
      check("umax product", product, 20'hFF801);
      release10();
      check("umax in_ready", in_ready, 1);

      op10(10'h200, 10'h200, 1'b1, 20'h40000, "s -512*-512");
      op10(10'h200, 10'h1FF, 1'b1, 20'hC0200, "s -512*511");
      op10(10'h3FF, 10'd5,   1'b1, 20'hFFFFB, "s -1*5");
      op10(10'd0,   10'h3FD, 1'b1, 20'h00000, "s 0*-3");
      op10(10'h3FF, 10'h002, 1'b0, 20'h007FE, "mode unsigned");
      op10(10'h3FF, 10'h002, 1'b1, 20'hFFFFE, "mode signed");

      // Backpressure, with operand noise in BUSY and DONE
      start10(10'd3, 10'd5, 1'b0);
      in_valid = 1'b1; a = 10'd100; b = 10'd100; sm = 1'b1;
      wait_done10(lat, nb);
      check("bp latency", lat, 10);
      check("bp product", product, 20'd15);
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = i[0]; a = 10'(i); b = 10'(i + 7);
         @(posedge clk); #1;
         if (!(out_valid === 1'b1 && product === 20'd15 && in_ready === 1'b0)) stable = 1'b0;
      end
      check("bp hold stable", stable, 1);
      in_valid = 1'b0;
      release10();
      check("bp release in_ready", in_ready, 1);
      check("bp release out_valid", out_valid, 0);
      op10(10'd7, 10'd8, 1'b1, 20'd56, "after bp");

      // Asynchronous reset in the 4th BUSY cycle
      start10(10'd300, 10'd300, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      check("mid busy before rst", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("rst out_valid", out_valid, 0);
      check("rst busy", busy, 0);
      check("rst in_ready", in_ready, 1);
      check("rst product", product, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      op10(10'd7, 10'd6, 1'b0, 20'd42, "post rst 7*6");

      // Parameter sweep
      for (int s = 0; s < 2; s++)
         for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
               run_sw(0, 16'(x), 16'(y), s[0], $sformatf("w2 a=%0d b=%0d sm=%0d", x, y, s));
      for (int s = 0; s < 2; s++)
         for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
               run_sw(1, 16'(x), 16'(y), s[0], $sformatf("w4 a=%0d b=%0d sm=%0d", x, y, s));
      run_sw(2, 16'h8000, 16'h8000, 1'b1, "w16 min*min");
      run_sw(2, 16'hFFFF, 16'hFFFF, 1'b0, "w16 umax");
      for (int i = 0; i < 40; i++) begin
         logic [15:0] rx, ry;
         rx = 16'($urandom);
         ry = 16'($urandom);
         run_sw(2, rx, ry, i[0], $sformatf("w16 rnd a=%0h b=%0h sm=%0d", rx, ry, i[0]));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Iterative shift-add multiplier, parametrised in operand width. Computes a full-width product of two WIDTH-bit operands, one multiplier bit per clock.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Uses valid/ready handshakes on input and output, so it can sit in a streaming datapath where area matters more than throughput.
- Successor to the team's combinational array and behavioural multipliers.

Parameters:
WIDTH, 10, operand width in bits (legal range 2..32); product width is 2*WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands and mode are valid this cycle
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
signed_mode  input  1  1 = a and b are two's complement; 0 = unsigned
out_valid  output  1  product is valid (high only in DONE)
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  result (two's complement when signed_mode was 1)
busy  output  1  high in BUSY state

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, bit counter=0, all internal registers=0. Any operation in progress is discarded.
- State IDLE:
  - in_ready=1.
  - On an edge where in_valid&in_ready, capture:
    - mag_a = |a| and mag_b = |b| when signed_mode=1 and the MSB is set; otherwise the raw value.
    - neg = signed_mode & (a[MSB]^b[MSB]).
  - Clear the accumulator and counter, then go to BUSY.
- Magnitude width:
  - Magnitudes are held in WIDTH-bit unsigned registers, so the most negative value (-2^(WIDTH-1)) maps to magnitude 2^(WIDTH-1) without overflow.
  - The accumulator is 2*WIDTH bits.
- State BUSY (busy=1, in_ready=0):
  - On each edge: if mag_b[counter]=1, accumulator += mag_a << counter; then counter += 1.
  - On the edge that processes bit WIDTH-1:
    - product <= neg ? -(final accumulator) : final accumulator, computed modulo 2^(2*WIDTH).
    - State goes to DONE.
- Latency: if operands are accepted at edge k, out_valid=1 is visible after edge k+WIDTH. Latency is fixed; there is no early termination on zero or leading-zero multiplier bits.
- State DONE:
  - out_valid=1; product is held stable.
  - On an edge with out_valid&out_ready: out_valid=0, state goes to IDLE. in_ready rises the cycle after.
- Input handling outside IDLE:
  - in_valid is ignored in BUSY and DONE.
  - a, b and signed_mode may change after acceptance without affecting the result.
- Backpressure: out_ready low holds DONE and product indefinitely.
- Throughput: at most one operation per WIDTH+2 cycles.
- Product register retains its last value in IDLE and BUSY until it is overwritten at completion.
- Zero operands (a=0 or b=0) give product 0 in both modes. A negative sign combined with a zero magnitude must not yield a nonzero result.

Test Plan:
- Unsigned max: WIDTH=10, signed_mode=0, a=1023, b=1023 -> product=20'hFF801, out_valid exactly 10 cycles after acceptance, busy high for those 10 cycles.
- Signed corner cases, WIDTH=10, signed_mode=1:
  - a=-512, b=-512 -> 20'h40000.
  - a=-512, b=511 -> 20'hC0200.
  - a=-1, b=5 -> 20'hFFFFB.
  - a=0, b=-3 -> 20'h00000.
- Mode contrast: a=10'h3FF, b=10'h002, signed_mode=0 -> 20'h007FE; same operands with signed_mode=1 -> 20'hFFFFE.
- Backpressure and ignore:
  - Hold out_ready=0 for 20 cycles after completion -> out_valid and product stay stable, in_ready stays 0.
  - Pulse in_valid with new operands during BUSY and DONE -> no effect on the current result.
  - Release out_ready -> IDLE, and the next operation proceeds normally.
- Reset mid-operation: assert rst asynchronously at BUSY cycle 4 -> immediately out_valid=0, busy=0, in_ready=1, product=0. After rst deasserts, a=7, b=6 unsigned -> 20'd42.
- Parameter sweep: WIDTH=2, 4 and 16. Random and exhaustive (WIDTH=4) operands in both modes are checked against a golden reference. Latency equals WIDTH in every case.
